// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: redirect/stall/flush controls, instruction-memory port and IF/ID outputs.
// Perf counter signals exist only when FETCH_PERF_CNT_EN is defined.
interface fetch_stage_if;
  logic        stall;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        if_id_valid;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_pc_plus4;
  logic [31:0] if_id_instr;
  logic        pc_out_of_range;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_bubbles;
`endif

  modport master (
    input  stall, flush, redirect_valid, redirect_pc, imem_instr,
`ifdef FETCH_PERF_CNT_EN
    output perf_fetched, perf_bubbles,
`endif
    output imem_addr, if_id_valid, if_id_pc, if_id_pc_plus4, if_id_instr, pc_out_of_range
  );

  modport slave (
    output stall, flush, redirect_valid, redirect_pc, imem_instr,
`ifdef FETCH_PERF_CNT_EN
    input  perf_fetched, perf_bubbles,
`endif
    input  imem_addr, if_id_valid, if_id_pc, if_id_pc_plus4, if_id_instr, pc_out_of_range
  );
endinterface

// File: rtl/fetch_stage.sv
// RISC-V fetch stage: PC register, combinational imem address, IF/ID register; one-edge fetch latency.
// Stall holds PC and IF/ID; flush/redirect bubble IF/ID. Optional FETCH_PERF_CNT_EN adds saturating counters.
module fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0013,
  parameter int unsigned IMEM_WORDS = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  fetch_stage_if.master bus
);

  logic [31:0] pc_q, pc_d, pc_plus4;
  logic        valid_q, valid_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic [31:0] id_pc4_q, id_pc4_d;
  logic        bubble, capture;
  logic        unused_redirect_lsbs;

  // Targets are word aligned; the two low bits of the redirect address are dropped.
  assign unused_redirect_lsbs = ^bus.redirect_pc[1:0];

  always_comb begin
    pc_plus4 = pc_q + 32'd4;
    bubble   = bus.redirect_valid | bus.flush;
    capture  = !bubble && !bus.stall;

    pc_d = pc_plus4;
    if (bus.redirect_valid) begin
      pc_d = {bus.redirect_pc[31:2], 2'b00};
    end else if (bus.stall) begin
      pc_d = pc_q;
    end

    valid_d  = valid_q;
    instr_d  = instr_q;
    id_pc_d  = id_pc_q;
    id_pc4_d = id_pc4_q;
    if (bubble) begin
      valid_d = 1'b0;
      instr_d = NOP_INSTR;
    end else if (capture) begin
      valid_d  = 1'b1;
      instr_d  = bus.imem_instr;
      id_pc_d  = pc_q;
      id_pc4_d = pc_plus4;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q     <= RESET_PC;
      valid_q  <= 1'b0;
      instr_q  <= NOP_INSTR;
      id_pc_q  <= 32'h0;
      id_pc4_q <= 32'h0;
    end else begin
      pc_q     <= pc_d;
      valid_q  <= valid_d;
      instr_q  <= instr_d;
      id_pc_q  <= id_pc_d;
      id_pc4_q <= id_pc4_d;
    end
  end

  assign bus.imem_addr       = pc_q;
  assign bus.if_id_valid     = valid_q;
  assign bus.if_id_instr     = instr_q;
  assign bus.if_id_pc        = id_pc_q;
  assign bus.if_id_pc_plus4  = id_pc4_q;
  assign bus.pc_out_of_range = ({2'b00, pc_q[31:2]} >= IMEM_WORDS);

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched_q, perf_fetched_d;
  logic [31:0] perf_bubbles_q, perf_bubbles_d;

  always_comb begin
    perf_fetched_d = perf_fetched_q;
    perf_bubbles_d = perf_bubbles_q;
    if (capture && (perf_fetched_q != 32'hFFFF_FFFF)) begin
      perf_fetched_d = perf_fetched_q + 32'd1;
    end
    if (bubble && (perf_bubbles_q != 32'hFFFF_FFFF)) begin
      perf_bubbles_d = perf_bubbles_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched_q <= 32'h0;
      perf_bubbles_q <= 32'h0;
    end else begin
      perf_fetched_q <= perf_fetched_d;
      perf_bubbles_q <= perf_bubbles_d;
    end
  end

  assign bus.perf_fetched = perf_fetched_q;
  assign bus.perf_bubbles = perf_bubbles_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: vector table for the fetch/stall/redirect/flush sequence plus reset and saturation sequences.
`timescale 1ns/1ps
module tb_fetch_stage;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fetch_stage_if bus();

  fetch_stage dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Instruction memory image: word at address a is a ^ 32'h5A00_0000.
  assign bus.imem_instr = bus.imem_addr ^ 32'h5A00_0000;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        stall;
    logic        flush;
    logic        redir;
    logic [31:0] rpc;
    logic [31:0] e_addr;
    logic        e_oor;
    logic        e_valid;
    logic [31:0] e_pc;
    logic [31:0] e_pc4;
    logic [31:0] e_instr;
    logic [31:0] e_fet;
    logic [31:0] e_bub;
  } vec_t;

  function automatic vec_t mk(input logic s, input logic f, input logic r, input logic [31:0] rpc,
                              input logic [31:0] addr, input logic oor, input logic v,
                              input logic [31:0] pc, input logic [31:0] pc4, input logic [31:0] ins,
                              input logic [31:0] fet, input logic [31:0] bub);
    vec_t t;
    t.stall = s; t.flush = f; t.redir = r; t.rpc = rpc;
    t.e_addr = addr; t.e_oor = oor; t.e_valid = v;
    t.e_pc = pc; t.e_pc4 = pc4; t.e_instr = ins;
    t.e_fet = fet; t.e_bub = bub;
    return t;
  endfunction

  localparam logic [31:0] NOP = 32'h0000_0013;
  vec_t vecs[20];

  initial begin
    //            s  f  r  rpc           addr          oor v  pc            pc4           instr         fet bub
    vecs[0]  = mk(0, 0, 0, 32'h0,        32'h0,        0,  1, 32'h0,        32'h4,        32'h5A000000, 1,  0);
    vecs[1]  = mk(0, 0, 0, 32'h0,        32'h4,        0,  1, 32'h4,        32'h8,        32'h5A000004, 2,  0);
    vecs[2]  = mk(1, 0, 0, 32'h0,        32'h8,        0,  1, 32'h4,        32'h8,        32'h5A000004, 2,  0);
    vecs[3]  = mk(1, 0, 0, 32'h0,        32'h8,        0,  1, 32'h4,        32'h8,        32'h5A000004, 2,  0);
    vecs[4]  = mk(0, 0, 0, 32'h0,        32'h8,        0,  1, 32'h8,        32'hC,        32'h5A000008, 3,  0);
    vecs[5]  = mk(0, 0, 1, 32'h42,       32'hC,        0,  0, 32'h8,        32'hC,        NOP,          3,  1);
    vecs[6]  = mk(0, 0, 0, 32'h0,        32'h40,       0,  1, 32'h40,       32'h44,       32'h5A000040, 4,  1);
    vecs[7]  = mk(1, 0, 1, 32'h20,       32'h44,       0,  0, 32'h40,       32'h44,       NOP,          4,  2);
    vecs[8]  = mk(0, 0, 0, 32'h0,        32'h20,       0,  1, 32'h20,       32'h24,       32'h5A000020, 5,  2);
    vecs[9]  = mk(0, 1, 0, 32'h0,        32'h24,       0,  0, 32'h20,       32'h24,       NOP,          5,  3);
    vecs[10] = mk(1, 1, 0, 32'h0,        32'h28,       0,  0, 32'h20,       32'h24,       NOP,          5,  4);
    vecs[11] = mk(0, 0, 1, 32'h28,       32'h28,       0,  0, 32'h20,       32'h24,       NOP,          5,  5);
    vecs[12] = mk(0, 0, 0, 32'h0,        32'h28,       0,  1, 32'h28,       32'h2C,       32'h5A000028, 6,  5);
    vecs[13] = mk(0, 0, 1, 32'h100,      32'h2C,       0,  0, 32'h28,       32'h2C,       NOP,          6,  6);
    vecs[14] = mk(0, 0, 0, 32'h0,        32'h100,      1,  1, 32'h100,      32'h104,      32'h5A000100, 7,  6);
    vecs[15] = mk(0, 0, 1, 32'hFC,       32'h104,      1,  0, 32'h100,      32'h104,      NOP,          7,  7);
    vecs[16] = mk(0, 0, 0, 32'h0,        32'hFC,       0,  1, 32'hFC,       32'h100,      32'h5A0000FC, 8,  7);
    vecs[17] = mk(0, 0, 1, 32'hFFFFFFFF, 32'h100,      1,  0, 32'hFC,       32'h100,      NOP,          8,  8);
    vecs[18] = mk(0, 0, 0, 32'h0,        32'hFFFFFFFC, 1,  1, 32'hFFFFFFFC, 32'h0,        32'hA5FFFFFC, 9,  8);
    vecs[19] = mk(0, 0, 0, 32'h0,        32'h0,        0,  1, 32'h0,        32'h4,        32'h5A000000, 10, 8);

    bus.stall = 1'b0;
    bus.flush = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = 32'h0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_addr",  bus.imem_addr, 32'h0);
    chk("rst_valid", {31'b0, bus.if_id_valid}, 32'h0);
    chk("rst_instr", bus.if_id_instr, NOP);
    chk("rst_pc",    bus.if_id_pc, 32'h0);
    chk("rst_pc4",   bus.if_id_pc_plus4, 32'h0);
`ifdef FETCH_PERF_CNT_EN
    chk("rst_fet",   bus.perf_fetched, 32'h0);
    chk("rst_bub",   bus.perf_bubbles, 32'h0);
`endif

    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      rst_n = 1'b1;
      bus.stall          = vecs[i].stall;
      bus.flush          = vecs[i].flush;
      bus.redirect_valid = vecs[i].redir;
      bus.redirect_pc    = vecs[i].rpc;
      #1;
      chk($sformatf("v%0d_addr", i), bus.imem_addr, vecs[i].e_addr);
      chk($sformatf("v%0d_oor", i), {31'b0, bus.pc_out_of_range}, {31'b0, vecs[i].e_oor});
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_valid", i), {31'b0, bus.if_id_valid}, {31'b0, vecs[i].e_valid});
      chk($sformatf("v%0d_pc", i), bus.if_id_pc, vecs[i].e_pc);
      chk($sformatf("v%0d_pc4", i), bus.if_id_pc_plus4, vecs[i].e_pc4);
      chk($sformatf("v%0d_instr", i), bus.if_id_instr, vecs[i].e_instr);
`ifdef FETCH_PERF_CNT_EN
      chk($sformatf("v%0d_fet", i), bus.perf_fetched, vecs[i].e_fet);
      chk($sformatf("v%0d_bub", i), bus.perf_bubbles, vecs[i].e_bub);
`endif
    end

    // Asynchronous reset asserted mid-cycle while a redirect is pending.
    @(negedge clk);
    bus.stall = 1'b0;
    bus.flush = 1'b0;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h80;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_addr",  bus.imem_addr, 32'h0);
    chk("arst_valid", {31'b0, bus.if_id_valid}, 32'h0);
    chk("arst_instr", bus.if_id_instr, NOP);
    chk("arst_pc",    bus.if_id_pc, 32'h0);
    chk("arst_pc4",   bus.if_id_pc_plus4, 32'h0);
`ifdef FETCH_PERF_CNT_EN
    chk("arst_fet",   bus.perf_fetched, 32'h0);
    chk("arst_bub",   bus.perf_bubbles, 32'h0);
`endif
    @(posedge clk);
    #1;
    chk("arst_hold_addr", bus.imem_addr, 32'h0);
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    chk("rel_addr", bus.imem_addr, 32'h0);
    @(posedge clk);
    #1;
    chk("rel_valid", {31'b0, bus.if_id_valid}, 32'h1);
    chk("rel_pc",    bus.if_id_pc, 32'h0);
    chk("rel_instr", bus.if_id_instr, 32'h5A000000);
    chk("rel_next",  bus.imem_addr, 32'h4);

`ifdef FETCH_PERF_CNT_EN
    @(negedge clk);
    dut.perf_fetched_q = 32'hFFFF_FFFE;
    dut.perf_bubbles_q = 32'hFFFF_FFFF;
    @(posedge clk);
    #1;
    chk("sat_fet1", bus.perf_fetched, 32'hFFFF_FFFF);
    @(posedge clk);
    #1;
    chk("sat_fet2", bus.perf_fetched, 32'hFFFF_FFFF);
    @(negedge clk);
    bus.flush = 1'b1;
    @(posedge clk);
    #1;
    chk("sat_bub", bus.perf_bubbles, 32'hFFFF_FFFF);
    chk("sat_fet3", bus.perf_fetched, 32'hFFFF_FFFF);
    @(negedge clk);
    bus.flush = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
